// File: rtl/ysyx_22040759_rdarb.sv
// Read-port arbiter: shares one AXI read master between IF and MEM.
// One outstanding read; ties go to the requester not served last.
module ysyx_22040759_rdarb #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic [1:0]            if_size_i,
  input  logic                  if_flush_i,
  output logic                  if_ready_o,
  output logic [DATA_WIDTH-1:0] if_data_o,
  input  logic                  mem_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [1:0]            mem_size_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  rd_addr_valid_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [1:0]            rd_size_o,
  input  logic                  rd_data_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BUSY_IF  = 2'd1,
    S_BUSY_MEM = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  drop_q, drop_d;
  logic                  avalid_q, avalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  grant_if;
  logic                  grant_mem;

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
      drop_q       <= 1'b0;
      avalid_q     <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
      avalid_q     <= avalid_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
    end
  end

  // Arbitration, latching and completion
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    avalid_d     = avalid_q;
    addr_d       = addr_q;
    size_d       = size_q;
    // A tie goes to the side that is not last_grant (0=IF, 1=MEM)
    grant_if     = if_valid_i & (~mem_valid_i | last_grant_q);
    grant_mem    = mem_valid_i & (~if_valid_i | ~last_grant_q);
    unique case (state_q)
      S_IDLE: begin
        if (grant_if) begin
          state_d      = S_BUSY_IF;
          last_grant_d = 1'b0;
          drop_d       = 1'b0;
          avalid_d     = 1'b1;
          addr_d       = if_addr_i;
          size_d       = if_size_i;
        end else if (grant_mem) begin
          state_d      = S_BUSY_MEM;
          last_grant_d = 1'b1;
          drop_d       = 1'b0;
          avalid_d     = 1'b1;
          addr_d       = mem_addr_i;
          size_d       = mem_size_i;
        end
      end
      S_BUSY_IF: begin
        if (if_flush_i) begin
          drop_d = 1'b1;
        end
        if (rd_data_valid_i) begin
          state_d  = S_IDLE;
          avalid_d = 1'b0;
        end
      end
      S_BUSY_MEM: begin
        if (rd_data_valid_i) begin
          state_d  = S_IDLE;
          avalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        avalid_d = 1'b0;
      end
    endcase
  end

  // Combinational response routing to the winner
  always_comb begin
    if_ready_o      = rd_data_valid_i & (state_q == S_BUSY_IF)
                    & ~drop_q & ~if_flush_i;
    mem_ready_o     = rd_data_valid_i & (state_q == S_BUSY_MEM);
    if_data_o       = rd_data_i;
    mem_data_o      = rd_data_i;
    rd_addr_valid_o = avalid_q;
    rd_addr_o       = addr_q;
    rd_size_o       = size_q;
  end

endmodule

// File: tb/tb_ysyx_22040759_rdarb.sv
// Directed bench for the read-port arbiter.
// Inputs change 1ns after posedge; outputs checked 2ns after posedge.
module tb_ysyx_22040759_rdarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [63:0] if_addr_i;
  logic [1:0]  if_size_i;
  logic        if_flush_i;
  logic        if_ready_o;
  logic [63:0] if_data_o;
  logic        mem_valid_i;
  logic [63:0] mem_addr_i;
  logic [1:0]  mem_size_i;
  logic        mem_ready_o;
  logic [63:0] mem_data_o;
  logic        rd_addr_valid_o;
  logic [63:0] rd_addr_o;
  logic [1:0]  rd_size_o;
  logic        rd_data_valid_i;
  logic [63:0] rd_data_i;

  int checks = 0;
  int failures = 0;
  int pulses;

  always #5 clk = ~clk;

  ysyx_22040759_rdarb #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid_i      (if_valid_i),
    .if_addr_i       (if_addr_i),
    .if_size_i       (if_size_i),
    .if_flush_i      (if_flush_i),
    .if_ready_o      (if_ready_o),
    .if_data_o       (if_data_o),
    .mem_valid_i     (mem_valid_i),
    .mem_addr_i      (mem_addr_i),
    .mem_size_i      (mem_size_i),
    .mem_ready_o     (mem_ready_o),
    .mem_data_o      (mem_data_o),
    .rd_addr_valid_o (rd_addr_valid_o),
    .rd_addr_o       (rd_addr_o),
    .rd_size_o       (rd_size_o),
    .rd_data_valid_i (rd_data_valid_i),
    .rd_data_i       (rd_data_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_valid_i = 1'b0; if_addr_i = '0; if_size_i = 2'd0;
    if_flush_i = 1'b0;
    mem_valid_i = 1'b0; mem_addr_i = '0; mem_size_i = 2'd0;
    rd_data_valid_i = 1'b0; rd_data_i = '0;
    tick(); tick();
    settle();
    chk("rst_avalid", {63'd0, rd_addr_valid_o}, 64'd0);
    chk("rst_addr", rd_addr_o, 64'd0);
    chk("rst_size", {62'd0, rd_size_o}, 64'd0);

    // IF alone
    rst = 1'b0;
    if_valid_i = 1'b1; if_addr_i = 64'h8000_0000; if_size_i = 2'd3;
    settle();
    chk("rel_if_ready", {63'd0, if_ready_o}, 64'd0);
    chk("rel_mem_ready", {63'd0, mem_ready_o}, 64'd0);
    tick(); settle();
    chk("t1_avalid", {63'd0, rd_addr_valid_o}, 64'd1);
    chk("t1_addr", rd_addr_o, 64'h8000_0000);
    chk("t1_size", {62'd0, rd_size_o}, 64'd3);
    tick(); settle();
    chk("t1_wait_if", {63'd0, if_ready_o}, 64'd0);
    rd_data_valid_i = 1'b1; rd_data_i = 64'h1122334455667788;
    settle();
    chk("t1_if_ready", {63'd0, if_ready_o}, 64'd1);
    chk("t1_if_data", if_data_o, 64'h1122334455667788);
    chk("t1_mem_ready", {63'd0, mem_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0; if_valid_i = 1'b0;
    settle();
    chk("t1_r1_avalid", {63'd0, rd_addr_valid_o}, 64'd0);
    chk("t1_r1_if_ready", {63'd0, if_ready_o}, 64'd0);

    // Tie right after reset: MEM first, then IF
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_valid_i = 1'b1; if_addr_i = 64'h8000_0004; if_size_i = 2'd2;
    mem_valid_i = 1'b1; mem_addr_i = 64'h8000_1000; mem_size_i = 2'd3;
    tick(); settle();
    chk("t2_g1_addr", rd_addr_o, 64'h8000_1000);
    chk("t2_g1_avalid", {63'd0, rd_addr_valid_o}, 64'd1);
    rd_data_valid_i = 1'b1; rd_data_i = 64'hAAAA_0000_BBBB_1111;
    settle();
    chk("t2_mem_ready", {63'd0, mem_ready_o}, 64'd1);
    chk("t2_mem_data", mem_data_o, 64'hAAAA_0000_BBBB_1111);
    chk("t2_if_not_ready", {63'd0, if_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0; mem_valid_i = 1'b0;
    settle();
    chk("t2_gap_avalid", {63'd0, rd_addr_valid_o}, 64'd0);
    tick(); settle();
    chk("t2_g2_avalid", {63'd0, rd_addr_valid_o}, 64'd1);
    chk("t2_g2_addr", rd_addr_o, 64'h8000_0004);
    chk("t2_g2_size", {62'd0, rd_size_o}, 64'd2);
    rd_data_valid_i = 1'b1; rd_data_i = 64'h5;
    settle();
    chk("t2_if_ready", {63'd0, if_ready_o}, 64'd1);
    chk("t2_mem_idle", {63'd0, mem_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0; if_valid_i = 1'b0;
    tick();

    // Both held: MEM, IF, MEM, IF (last grant was IF)
    pulses = 0;
    if_valid_i = 1'b1; if_addr_i = 64'h10;
    mem_valid_i = 1'b1; mem_addr_i = 64'h20;
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      chk("t3_avalid", {63'd0, rd_addr_valid_o}, 64'd1);
      chk("t3_addr", rd_addr_o, (i % 2 == 0) ? 64'h20 : 64'h10);
      rd_data_valid_i = 1'b1; rd_data_i = 64'(i);
      settle();
      chk("t3_mem_ready", {63'd0, mem_ready_o},
          (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t3_if_ready", {63'd0, if_ready_o},
          (i % 2 == 0) ? 64'd0 : 64'd1);
      pulses += int'(if_ready_o) + int'(mem_ready_o);
      tick();
      rd_data_valid_i = 1'b0;
      if (i == 3) begin
        if_valid_i = 1'b0; mem_valid_i = 1'b0;
      end
      settle();
      chk("t3_gap", {63'd0, rd_addr_valid_o}, 64'd0);
    end
    chk("t3_pulses", 64'(pulses), 64'd4);
    tick();

    // Flush mid BUSY_IF with MEM pending
    if_valid_i = 1'b1; if_addr_i = 64'h300;
    tick(); settle();
    chk("t4_if_addr", rd_addr_o, 64'h300);
    mem_valid_i = 1'b1; mem_addr_i = 64'h400;
    if_flush_i = 1'b1;
    tick();
    if_flush_i = 1'b0; if_valid_i = 1'b0;
    tick();
    rd_data_valid_i = 1'b1; rd_data_i = 64'hDEAD;
    settle();
    chk("t4_dropped", {63'd0, if_ready_o}, 64'd0);
    chk("t4_no_mem", {63'd0, mem_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0;
    settle();
    chk("t4_idle", {63'd0, rd_addr_valid_o}, 64'd0);
    tick(); settle();
    chk("t4_mem_grant", {63'd0, rd_addr_valid_o}, 64'd1);
    chk("t4_mem_addr", rd_addr_o, 64'h400);
    rd_data_valid_i = 1'b1;
    settle();
    chk("t4_mem_ready", {63'd0, mem_ready_o}, 64'd1);
    tick();
    rd_data_valid_i = 1'b0; mem_valid_i = 1'b0;
    tick();

    // Flush in the completion cycle itself
    if_valid_i = 1'b1; if_addr_i = 64'h500;
    tick();
    rd_data_valid_i = 1'b1; if_flush_i = 1'b1;
    settle();
    chk("t4b_flush_r", {63'd0, if_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0; if_flush_i = 1'b0; if_valid_i = 1'b0;
    tick();

    // Reset during BUSY_MEM
    mem_valid_i = 1'b1; mem_addr_i = 64'h600; mem_size_i = 2'd1;
    tick(); settle();
    chk("t5_busy", {63'd0, rd_addr_valid_o}, 64'd1);
    rst = 1'b1; mem_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("t5_avalid", {63'd0, rd_addr_valid_o}, 64'd0);
    chk("t5_addr", rd_addr_o, 64'd0);
    chk("t5_size", {62'd0, rd_size_o}, 64'd0);
    rd_data_valid_i = 1'b1;
    settle();
    chk("t5_no_mem", {63'd0, mem_ready_o}, 64'd0);
    chk("t5_no_if", {63'd0, if_ready_o}, 64'd0);
    tick();
    rd_data_valid_i = 1'b0;
    settle();
    chk("t5_still_idle", {63'd0, rd_addr_valid_o}, 64'd0);

    // Address stays latched while MEM input changes
    mem_valid_i = 1'b1; mem_addr_i = 64'h100; mem_size_i = 2'd2;
    tick(); settle();
    chk("t6_addr0", rd_addr_o, 64'h100);
    mem_addr_i = 64'h200; mem_size_i = 2'd0;
    tick(); settle();
    chk("t6_addr1", rd_addr_o, 64'h100);
    chk("t6_size1", {62'd0, rd_size_o}, 64'd2);
    tick();
    rd_data_valid_i = 1'b1;
    settle();
    chk("t6_addr_r", rd_addr_o, 64'h100);
    chk("t6_ready", {63'd0, mem_ready_o}, 64'd1);
    tick();
    rd_data_valid_i = 1'b0; mem_valid_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
